// File: rtl/filter_pkg.sv
// Shared types and constants for the FIR filter engine.
// Holds the FSM state encoding and the default coefficient set.
package filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } filt_state_t;

   localparam int FILT_NTAPS      = 8;
   localparam int FILT_COEF_WIDTH = 12;

   // 8 taps of 256 in Q1.11: moving average with unity gain
   localparam logic [FILT_NTAPS*FILT_COEF_WIDTH-1:0] FILT_DEFAULT_COEFS =
      {FILT_NTAPS{12'd256}};

   function automatic int unsigned filt_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/filter_mac.sv
// Signed multiply-accumulate with round-half-up and saturation to the sample width.
// Sequenced entirely by the clear/accumulate/round strobes from filter_unit.
module filter_mac
   import filter_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int NTAPS      = 8,
   parameter int COEF_WIDTH = 12,
   parameter int FRAC_BITS  = 11,
   parameter logic [NTAPS*COEF_WIDTH-1:0] COEFS = FILT_DEFAULT_COEFS,
   localparam int IDX_W = filt_idx_width(NTAPS)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         acc_en,
   input  logic                         round_en,
   input  logic [IDX_W-1:0]             idx,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic [DATA_WIDTH-1:0]        result
);

   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(NTAPS);

   localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] SAT_HI =
      {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO =
      {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [COEF_WIDTH-1:0] coef_tab [NTAPS];
   logic signed [COEF_WIDTH-1:0] coef_sel;
   logic signed [PROD_W-1:0]     prod;
   logic signed [ACC_W-1:0]      acc;
   logic signed [ACC_W-1:0]      rnd;
   logic [DATA_WIDTH-1:0]        sat;

   for (genvar g = 0; g < NTAPS; g++) begin : g_coef
      assign coef_tab[g] = COEFS[g*COEF_WIDTH +: COEF_WIDTH];
   end

   assign coef_sel = coef_tab[idx];
   assign prod     = PROD_W'(sample) * PROD_W'(coef_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

   // Arithmetic shift floors, so adding half an LSB first rounds halves toward +inf
   always_comb begin
      rnd = (acc + ROUND_HALF) >>> FRAC_BITS;
      if (rnd > SAT_HI) begin
         sat = SAT_HI[DATA_WIDTH-1:0];
      end else if (rnd < SAT_LO) begin
         sat = SAT_LO[DATA_WIDTH-1:0];
      end else begin
         sat = rnd[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
      end else if (round_en) begin
         result <= sat;
      end
   end

endmodule

// File: rtl/filter_unit.sv
// FIR filter engine: collects NTAPS samples over a valid/request handshake,
// then returns one rounded, saturated result with a single-cycle done pulse.
module filter_unit
   import filter_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int NTAPS      = 8,
   parameter int COEF_WIDTH = 12,
   parameter int FRAC_BITS  = 11,
   parameter logic [NTAPS*COEF_WIDTH-1:0] COEFS = FILT_DEFAULT_COEFS
)(
   input  logic                  Filter_CLK,
   input  logic                  Filter_RST,
   input  logic                  Filter_EN,
   output logic                  Filter_SREQ,
   input  logic                  Filter_SVLD,
   input  logic [DATA_WIDTH-1:0] Filter_SIN,
   output logic                  Filter_BSY,
   output logic                  Filter_DNE,
   output logic [DATA_WIDTH-1:0] Filter_DATA
);

   localparam int IDX_W = filt_idx_width(NTAPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

   filt_state_t      state, next_state;
   logic [IDX_W-1:0] idx;
   logic             clr, acc_en, round_en;

   always_ff @(posedge Filter_CLK or negedge Filter_RST) begin
      if (!Filter_RST) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge Filter_CLK or negedge Filter_RST) begin
      if (!Filter_RST) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (acc_en) begin
         idx <= idx + 1'b1;
      end
   end

   // Outputs decode only the state register, so nothing reaches them from inputs
   always_comb begin
      next_state  = state;
      clr         = 1'b0;
      acc_en      = 1'b0;
      round_en    = 1'b0;
      Filter_SREQ = 1'b0;
      Filter_BSY  = 1'b1;
      Filter_DNE  = 1'b0;
      case (state)
         ST_IDLE: begin
            Filter_BSY = 1'b0;
            if (Filter_EN) begin
               clr        = 1'b1;
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            Filter_SREQ = 1'b1;
            if (Filter_SVLD) begin
               acc_en = 1'b1;
               if (idx == LAST_IDX) begin
                  next_state = ST_ROUND;
               end
            end
         end
         ST_ROUND: begin
            round_en   = 1'b1;
            next_state = ST_DONE;
         end
         ST_DONE: begin
            Filter_DNE = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   filter_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .NTAPS      (NTAPS),
      .COEF_WIDTH (COEF_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .COEFS      (COEFS)
   ) u_mac (
      .clk      (Filter_CLK),
      .rst_n    (Filter_RST),
      .clr      (clr),
      .acc_en   (acc_en),
      .round_en (round_en),
      .idx      (idx),
      .sample   (Filter_SIN),
      .result   (Filter_DATA)
   );

endmodule
